// File: rtl/pc_pkg.sv
// pc_pkg: shared widths, reset PC and next-PC source encoding for the PC unit
package pc_pkg;
  localparam int PC_W_DEF  = 12;
  localparam int IMM_W_DEF = 17;
  localparam int PC_RESET  = 0;
  typedef enum logic [2:0] {
    SRC_REPLAY, SRC_STALL, SRC_BRANCH, SRC_JRT, SRC_JT, SRC_SEQ
  } src_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
// Ports: clock, reset (async active-low), push_i/pop_i strobes, data_i pushed value,
//        top_o most recent entry, empty_o/full_o occupancy flags.
module pc_ras
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW:0]     cnt_q;
  logic [PW-1:0]   top_idx;
  // ptr_q is the next free slot, so the top lives one below it (mod depth)
  assign top_idx = ptr_q - 1'b1;
  assign top_o   = mem_q[top_idx];
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (PW+1)'(RAS_DEPTH);
  always_ff @(posedge clock)
    if (push_i) mem_q[ptr_q] <= data_i;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      ptr_q <= ptr_q + 1'b1;
      if (!full_o) cnt_q <= cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - 1'b1;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: registered program counter with startup replay and prioritised redirects
// Ports: clock, reset (async active-low); stall; branch_en/imm; jump_rt_en/jump_rt;
//        jump_t_en/jump_t; call_en; pc, next_pc, flush, first, ras_empty, ras_full.
// Build option: define PC_UNIT_RAS_EN to add a return-address stack for call/return.
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int IMM_W     = IMM_W_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [IMM_W-1:0] imm,
  input  logic             jump_rt_en,
  input  logic [PC_W-1:0]  jump_rt,
  input  logic             jump_t_en,
  input  logic [PC_W-1:0]  jump_t,
  input  logic             call_en,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  next_pc,
  output logic             flush,
  output logic             first,
  output logic             ras_empty,
  output logic             ras_full
);
  logic [PC_W-1:0] pc_q, imm_ext, jrt_tgt, seq_pc;
  logic            first_q, replay, unused_in;
  src_e            src;
  // sinks bits that are dropped by truncation or unused in a given build
  assign unused_in = ^{imm, call_en};
  generate
    if (IMM_W >= PC_W) begin : g_trunc
      assign imm_ext = imm[PC_W-1:0];
    end else begin : g_sext
      assign imm_ext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    end
  endgenerate
  // the very first cycle out of reset re-issues address 0 once
  assign replay = (pc_q == PC_W'(PC_RESET)) & ~first_q;
  assign seq_pc = pc_q + 1'b1;
  assign src = replay     ? SRC_REPLAY :
               stall      ? SRC_STALL  :
               branch_en  ? SRC_BRANCH :
               jump_rt_en ? SRC_JRT    :
               jump_t_en  ? SRC_JT     : SRC_SEQ;
`ifdef PC_UNIT_RAS_EN
  logic [PC_W-1:0] ras_top;
  pc_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clock   (clock),
    .reset   (reset),
    .push_i  (src == SRC_JT && call_en),
    .pop_i   (src == SRC_JRT),
    .data_i  (seq_pc),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );
  assign jrt_tgt = ras_empty ? jump_rt : ras_top;
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign jrt_tgt   = jump_rt;
`endif
  assign next_pc = (src == SRC_REPLAY) ? PC_W'(PC_RESET) :
                   (src == SRC_STALL)  ? pc_q            :
                   (src == SRC_BRANCH) ? pc_q + imm_ext  :
                   (src == SRC_JRT)    ? jrt_tgt         :
                   (src == SRC_JT)     ? jump_t          : seq_pc;
  assign flush = ~replay & ~stall & (branch_en | jump_rt_en | jump_t_en);
  assign pc    = pc_q;
  assign first = first_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pc_q    <= PC_W'(PC_RESET);
      first_q <= 1'b0;
    end else begin
      pc_q    <= next_pc;
      first_q <= first_q | replay;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit
module tb_pc_unit;
  logic        clock = 1'b0, reset = 1'b0, stall = 1'b0, branch_en = 1'b0;
  logic        jump_rt_en = 1'b0, jump_t_en = 1'b0, call_en = 1'b0;
  logic [16:0] imm = '0;
  logic [11:0] jump_rt = '0, jump_t = '0, pc, next_pc;
  logic        flush, first, ras_empty, ras_full;
  int          n_run = 0, n_fail = 0;

  pc_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_en(branch_en), .imm(imm),
    .jump_rt_en(jump_rt_en), .jump_rt(jump_rt), .jump_t_en(jump_t_en), .jump_t(jump_t),
    .call_en(call_en), .pc(pc), .next_pc(next_pc), .flush(flush), .first(first),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_first", 32'(first), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_ras_empty", 32'(ras_empty), 1);
    chk("rst_ras_full", 32'(ras_full), 0);
    reset = 1'b1;
    #1 chk("replay_next", 32'(next_pc), 0);
    tick();
    chk("seq_pc0", 32'(pc), 0);
    chk("first_set", 32'(first), 1);
    chk("seq_flush", 32'(flush), 0);
    tick();
    chk("seq_pc1", 32'(pc), 1);
    tick();
    chk("seq_pc2", 32'(pc), 2);
    chk("seq_flush2", 32'(flush), 0);
    #2 reset = 1'b0;
    #1 chk("async_pc", 32'(pc), 0);
    chk("async_first", 32'(first), 0);
    @(negedge clock);
    reset = 1'b1;
    branch_en = 1'b1;
    imm = 17'd5;
    #1 chk("replay_br_flush", 32'(flush), 0);
    chk("replay_br_next", 32'(next_pc), 0);
    tick();
    chk("replay_br_pc", 32'(pc), 0);
    chk("post_replay_flush", 32'(flush), 1);
    chk("post_replay_next", 32'(next_pc), 5);
    tick();
    chk("branch_pc5", 32'(pc), 5);
    branch_en = 1'b0;
    jump_t_en = 1'b1;
    jump_t = 12'h010;
    tick();
    chk("jump_pc10", 32'(pc), 'h010);
    stall = 1'b1;
    branch_en = 1'b1;
    jump_rt_en = 1'b1;
    jump_rt = 12'h777;
    jump_t = 12'h333;
    imm = 17'h1FFFC;
    #1 chk("stall_next", 32'(next_pc), 'h010);
    chk("stall_flush", 32'(flush), 0);
    tick();
    chk("stall_pc", 32'(pc), 'h010);
    stall = 1'b0;
    #1 chk("prio_next", 32'(next_pc), 'h00C);
    chk("prio_flush", 32'(flush), 1);
    tick();
    chk("prio_pc", 32'(pc), 'h00C);
    branch_en = 1'b0;
    #1 chk("jr_over_j", 32'(next_pc), 'h777);
    tick();
    chk("jr_pc", 32'(pc), 'h777);
    jump_rt_en = 1'b0;
    #1 chk("j_next", 32'(next_pc), 'h333);
    jump_t = 12'hFFF;
    tick();
    chk("j_pcfff", 32'(pc), 'hFFF);
    jump_t_en = 1'b0;
    #1 chk("wrap_next", 32'(next_pc), 0);
    chk("wrap_flush", 32'(flush), 0);
    tick();
    chk("wrap_pc", 32'(pc), 0);
    chk("no_second_replay", 32'(next_pc), 1);
    jump_t_en = 1'b1;
    jump_t = 12'h002;
    tick();
    jump_t_en = 1'b0;
    branch_en = 1'b1;
    imm = 17'h1FFFD;
    #1 chk("neg_wrap_next", 32'(next_pc), 'hFFF);
    tick();
    chk("neg_wrap_pc", 32'(pc), 'hFFF);
    branch_en = 1'b0;
`ifdef PC_UNIT_RAS_EN
    jump_t_en = 1'b1;
    jump_t = 12'h100;
    tick();
    stall = 1'b1;
    call_en = 1'b1;
    jump_t = 12'h200;
    tick();
    chk("stall_call_pc", 32'(pc), 'h100);
    chk("stall_call_empty", 32'(ras_empty), 1);
    stall = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      jump_t = 12'((k + 1) << 8);
      tick();
      chk("call_pc", 32'(pc), 32'((k + 1) << 8));
      chk("call_full", 32'(ras_full), 32'(k >= 4));
    end
    call_en = 1'b0;
    jump_t_en = 1'b0;
    jump_rt_en = 1'b1;
    jump_rt = 12'hABC;
    begin
      logic [11:0] ret [5] = '{12'h501, 12'h401, 12'h301, 12'h201, 12'hABC};
      for (int k = 0; k < 5; k++) begin
        #1 chk("ret_next", 32'(next_pc), 32'(ret[k]));
        tick();
        chk("ret_pc", 32'(pc), 32'(ret[k]));
        chk("ret_empty", 32'(ras_empty), 32'(k >= 3));
      end
    end
`else
    jump_t_en = 1'b1;
    call_en = 1'b1;
    jump_t = 12'h100;
    tick();
    chk("call_pc", 32'(pc), 'h100);
    chk("noras_empty", 32'(ras_empty), 1);
    chk("noras_full", 32'(ras_full), 0);
    jump_t_en = 1'b0;
    call_en = 1'b0;
    jump_rt_en = 1'b1;
    jump_rt = 12'hABC;
    #1 chk("noras_ret", 32'(next_pc), 'hABC);
    tick();
`endif
    jump_rt_en = 1'b0;
    jump_t_en = 1'b1;
    call_en = 1'b1;
    jump_t = 12'h123;
    tick();
    chk("pre_reset_pc", 32'(pc), 'h123);
    jump_t_en = 1'b0;
    call_en = 1'b0;
    #2 reset = 1'b0;
    #1 chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_first", 32'(first), 0);
    chk("mid_rst_empty", 32'(ras_empty), 1);
    chk("mid_rst_flush", 32'(flush), 0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rereplay_next", 32'(next_pc), 0);
    tick();
    chk("rereplay_pc", 32'(pc), 0);
    chk("rereplay_first", 32'(first), 1);
    chk("rereplay_seq", 32'(next_pc), 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Registered program-counter unit for the lightbike processor core; successor to the combinational next-PC selector.
- Owns the PC register and the one-shot startup replay of address 0.
- Prioritises stall / branch / jump-return / jump-target redirects and raises flush to the decode stage.
- Generalised in PC and immediate width, and adds an optional return-address stack (RAS) for call/return.

Parameters:
PC_W, 12, program-counter width in bits
IMM_W, 17, branch immediate width (sign-extended to PC_W)
RAS_DEPTH, 4, return-address-stack entries (power of two, >=2; used only with RAS_EN)

Ports:
clock  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hold PC this cycle (nop insertion)
branch_en  input  1  take branch: target = pc + sext(imm)
imm  input  IMM_W  branch offset, two's complement
jump_rt_en  input  1  jump-return (jr)
jump_rt  input  PC_W  register-supplied return target
jump_t_en  input  1  jump to target (j/jal)
jump_t  input  PC_W  absolute jump target
call_en  input  1  qualifies jump_t_en as a call (jal); pushes pc+1 when RAS_EN
pc  output  PC_W  current PC register
next_pc  output  PC_W  value loaded at next edge
flush  output  1  redirect taken this cycle
first  output  1  startup replay completed
ras_empty  output  1  RAS holds no entries (tied 1 without RAS_EN)
ras_full  output  1  RAS holds RAS_DEPTH entries (tied 0 without RAS_EN)

Behaviour:
- Reset (reset low, async):
  - pc=0, first=0, RAS count=0 and pointer=0.
  - Outputs: flush=0, ras_empty=1, ras_full=0.
- Replay: when pc==0 and first==0, next_pc=0 and first<=1 at the edge.
  - Overrides every other input.
  - flush=0; no RAS activity.
  - first never clears except on reset.
- next_pc priority, highest first: replay > stall (hold pc) > branch_en > jump_rt_en > jump_t_en > pc+1.
- Arithmetic:
  - pc+1 and pc+sext(imm) are truncated to PC_W and wrap modulo 2^PC_W.
  - Example: pc=0xFFF gives pc+1=0x000.
- pc register: loads next_pc on every rising edge.
- flush (combinational) = ~replay & ~stall & (branch_en | jump_rt_en | jump_t_en).
- A stalled redirect is neither taken nor flushed. Upstream must hold the request until stall drops.
- All RAS updates are suppressed when stall, replay, or any higher-priority redirect wins.

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- With the macro:
  - A taken jump_t_en with call_en pushes pc+1 (wrapped).
  - A taken jump_rt_en pops. The target is the RAS top when not empty, otherwise the jump_rt port.
  - Push when full overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
  - Pop when empty leaves count at 0.
  - Push and pop cannot both be taken in one cycle, because priority selects one.
- Without the macro:
  - No storage; jump_rt_en always uses the jump_rt port.
  - call_en is ignored; ras_empty=1, ras_full=0.

Decomposition:
- Package pc_pkg holds:
  - default widths PC_W_DEF=12, IMM_W_DEF=17;
  - PC_RESET=0;
  - an enum of next-PC source {SRC_REPLAY, SRC_STALL, SRC_BRANCH, SRC_JRT, SRC_JT, SRC_SEQ} used by the selector and by bench coverage.
- One sub-module, pc_ras: circular stack with push/pop/top/empty/full, parameterised by PC_W and RAS_DEPTH.
  - pc_unit instantiates it only under PC_UNIT_RAS_EN.

Test Plan:
- Reset release, no redirects for 4 cycles -> pc sequence 0,0,1,2; first rises after the first edge; flush=0 throughout.
- Startup replay with branch_en=1 and imm=5 at pc=0 in the first cycle -> branch ignored; pc stays 0; the next cycle branches to 5 with flush=1.
- Priority at pc=0x010 (after replay):
  - branch_en, jump_rt_en and jump_t_en all set, imm=-4 -> next_pc=0x00C, flush=1.
  - Same cycle with stall=1 -> pc holds 0x010, flush=0.
- Wrap cases:
  - pc=0xFFF, no redirect -> 0x000.
  - pc=0x002, branch imm=-3 -> 0xFFF.
- RAS (PC_UNIT_RAS_EN, depth 4):
  - Calls from 0x100, 0x200, 0x300, 0x400, 0x500, then 5 returns with jump_rt=0xABC.
  - Returns yield 0x501, 0x401, 0x301, 0x201, then 0xABC (empty fallback).
  - ras_full is 1 after the 4th call; ras_empty is 1 after the 4th pop.
- Async reset asserted mid-run between edges -> pc=0, first=0, RAS empty immediately; after release, replay repeats 0 once.
